// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: AXI4-Lite response codes and elaboration helpers shared by the pcores.
package axi4_lite_pkg;
    localparam logic [1:0] AXI_RESP_OK     = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    function automatic int clog2(input int n);
        int r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction
endpackage

// File: rtl/axi4_lite_wstrb_merge.sv
// axi4_lite_wstrb_merge: byte-wise select between the held value and new write data.
module axi4_lite_wstrb_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   old_data,
    input  logic [DATA_WIDTH-1:0]   new_data,
    input  logic [DATA_WIDTH/8-1:0] strb,
    output logic [DATA_WIDTH-1:0]   merged
);
    for (genvar b = 0; b < DATA_WIDTH / 8; b++) begin : g_byte
        assign merged[b*8 +: 8] = strb[b] ? new_data[b*8 +: 8] : old_data[b*8 +: 8];
    end
endmodule

// File: rtl/axi4_lite_regfile.sv
// axi4_lite_regfile: AXI4-Lite slave with NUM_RW control and NUM_RO status registers,
// byte strobes, independent AW/W acceptance and per-register access strobes.
module axi4_lite_regfile
    import axi4_lite_pkg::*;
#(
    parameter int          DATA_WIDTH    = 32,
    parameter int          ADDR_WIDTH    = 32,
    parameter int          NUM_RW        = 8,
    parameter int          NUM_RO        = 8,
    parameter logic [31:0] RW_RESET_BASE = 32'h00007700
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    input  logic [ADDR_WIDTH-1:0]        AWADDR,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [DATA_WIDTH-1:0]        WDATA,
    input  logic [DATA_WIDTH/8-1:0]      WSTRB,
    input  logic                         WVALID,
    output logic                         WREADY,
    output logic [1:0]                   BRESP,
    output logic                         BVALID,
    input  logic                         BREADY,
    input  logic [ADDR_WIDTH-1:0]        ARADDR,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic [DATA_WIDTH-1:0]        RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RVALID,
    input  logic                         RREADY,
    input  logic [NUM_RO*DATA_WIDTH-1:0] ro_data,
    output logic [NUM_RW*DATA_WIDTH-1:0] rw_data,
    output logic [NUM_RW-1:0]            rw_wr_pulse,
    output logic [NUM_RO-1:0]            ro_rd_pulse
);
    localparam int NUM_REGS = NUM_RW + NUM_RO;
    localparam int IDX_W    = clog2(NUM_REGS);
    localparam int IW       = IDX_W > 0 ? IDX_W : 1;

    function automatic logic [IW-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W > 0 ? a[IW+1:2] : '0;
    endfunction

    logic                         aw_full, w_full;
    logic [IW-1:0]                aw_idx, ar_idx;
    logic [DATA_WIDTH-1:0]        w_data, rd_data;
    logic [DATA_WIDTH/8-1:0]      w_strb;
    logic [NUM_RW*DATA_WIDTH-1:0] merged;
    logic [1:0]                   rd_resp;
    logic aw_hs, w_hs, ar_hs, commit, aw_is_rw;
    logic aw_full_n, w_full_n, bvalid_n, rvalid_n;
    logic unused_addr_bits;

    assign aw_hs     = AWVALID & AWREADY;
    assign w_hs      = WVALID & WREADY;
    assign ar_hs     = ARVALID & ARREADY;
    assign commit    = aw_full & w_full;
    assign aw_is_rw  = int'(aw_idx) < NUM_RW;
    assign ar_idx    = addr_idx(ARADDR);
    assign aw_full_n = ~commit & (aw_full | aw_hs);
    assign w_full_n  = ~commit & (w_full | w_hs);
    assign bvalid_n  = commit | (BVALID & ~BREADY);
    assign rvalid_n  = ar_hs | (RVALID & ~RREADY);
    assign unused_addr_bits = &{1'b0, AWADDR, ARADDR};

    for (genvar i = 0; i < NUM_RW; i++) begin : g_rw
        axi4_lite_wstrb_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
            .old_data(rw_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .new_data(w_data),
            .strb    (w_strb),
            .merged  (merged[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_comb begin
        rd_data = '0;
        rd_resp = AXI_RESP_SLVERR;
        for (int i = 0; i < NUM_RW; i++)
            if (int'(ar_idx) == i) begin
                rd_data = rw_data[i*DATA_WIDTH +: DATA_WIDTH];
                rd_resp = AXI_RESP_OK;
            end
        for (int j = 0; j < NUM_RO; j++)
            if (int'(ar_idx) == NUM_RW + j) begin
                rd_data = ro_data[j*DATA_WIDTH +: DATA_WIDTH];
                rd_resp = AXI_RESP_OK;
            end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            aw_full     <= 1'b0;
            w_full      <= 1'b0;
            AWREADY     <= 1'b0;
            WREADY      <= 1'b0;
            ARREADY     <= 1'b0;
            BVALID      <= 1'b0;
            RVALID      <= 1'b0;
            BRESP       <= AXI_RESP_OK;
            RRESP       <= AXI_RESP_OK;
            RDATA       <= '0;
            rw_wr_pulse <= '0;
            ro_rd_pulse <= '0;
            for (int i = 0; i < NUM_RW; i++)
                rw_data[i*DATA_WIDTH +: DATA_WIDTH] <= DATA_WIDTH'(RW_RESET_BASE + 32'(i));
        end else begin
            aw_full <= aw_full_n;
            w_full  <= w_full_n;
            AWREADY <= ~aw_full_n & ~bvalid_n;
            WREADY  <= ~w_full_n & ~bvalid_n;
            BVALID  <= bvalid_n;
            RVALID  <= rvalid_n;
            ARREADY <= ~rvalid_n;
            if (aw_hs) aw_idx <= addr_idx(AWADDR);
            if (w_hs) begin
                w_data <= WDATA;
                w_strb <= WSTRB;
            end
            if (commit) BRESP <= aw_is_rw ? AXI_RESP_OK : AXI_RESP_SLVERR;
            // RDATA captures the pre-commit value when a write lands on the same edge
            if (ar_hs) begin
                RDATA <= rd_data;
                RRESP <= rd_resp;
            end
            for (int i = 0; i < NUM_RW; i++) begin
                rw_wr_pulse[i] <= commit && int'(aw_idx) == i;
                if (commit && int'(aw_idx) == i)
                    rw_data[i*DATA_WIDTH +: DATA_WIDTH] <= merged[i*DATA_WIDTH +: DATA_WIDTH];
            end
            for (int j = 0; j < NUM_RO; j++)
                ro_rd_pulse[j] <= ar_hs && int'(ar_idx) == NUM_RW + j;
        end
    end
endmodule

// File: tb/tb_axi4_lite_regfile.sv
// tb_axi4_lite_regfile: randomized AXI4-Lite traffic checked every cycle against a
// transaction-level model of the register file, plus directed literal checks.
module tb_axi4_lite_regfile;
    localparam int DW   = 32;
    localparam int NRW  = 8;
    localparam int NRO  = 6;
    localparam int NREG = NRW + NRO;
    localparam int MOD  = 16;  // smallest power of two covering NREG

    logic ACLK = 1'b0, ARESETN = 1'b0;
    logic [31:0] AWADDR = '0, ARADDR = '0;
    logic AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
    logic [DW-1:0] WDATA = '0;
    logic [3:0] WSTRB = '0;
    logic AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0] BRESP, RRESP;
    logic [DW-1:0] RDATA;
    logic [NRO*DW-1:0] ro_data = '0;
    logic [NRW*DW-1:0] rw_data;
    logic [NRW-1:0] rw_wr_pulse;
    logic [NRO-1:0] ro_rd_pulse;

    int n_checks = 0, n_fail = 0;

    axi4_lite_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(32), .NUM_RW(NRW), .NUM_RO(NRO)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .ro_data(ro_data), .rw_data(rw_data),
        .rw_wr_pulse(rw_wr_pulse), .ro_rd_pulse(ro_rd_pulse)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL timeout %s at %0t", name, $time);
    endtask

    function automatic int dec(input logic [31:0] a);
        return int'((a >> 2) % MOD);
    endfunction

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_rw [NRW];
    int            aw_q[$];
    logic [DW-1:0] wd_q[$];
    logic [3:0]    ws_q[$];
    bit e_awready, e_wready, e_arready, e_bvalid, e_rvalid, started;
    logic [1:0] e_bresp = 2'b00, e_rresp = 2'b00;
    logic [DW-1:0] e_rdata = '0;
    logic [NRW-1:0] e_wp = '0;
    logic [NRO-1:0] e_rp = '0;

    always @(posedge ACLK) begin : model
        int idx;
        logic [DW-1:0] d;
        logic [3:0] s;
        started = 1'b1;
        e_wp = '0;
        e_rp = '0;
        if (!ARESETN) begin
            for (int i = 0; i < NRW; i++) m_rw[i] = 32'h7700 + i;
            aw_q.delete();
            wd_q.delete();
            ws_q.delete();
            e_bvalid = 0;
            e_rvalid = 0;
            e_bresp = 2'b00;
            e_rresp = 2'b00;
            e_rdata = '0;
        end else begin
            if (e_rvalid && RREADY) e_rvalid = 0;
            else if (ARVALID && e_arready) begin
                idx = dec(ARADDR);
                e_rvalid = 1;
                if (idx < NRW) begin
                    e_rdata = m_rw[idx];
                    e_rresp = 2'b00;
                end else if (idx < NREG) begin
                    e_rdata = ro_data[(idx-NRW)*DW +: DW];
                    e_rresp = 2'b00;
                    e_rp[idx-NRW] = 1'b1;
                end else begin
                    e_rdata = '0;
                    e_rresp = 2'b10;
                end
            end
            if (e_bvalid && BREADY) e_bvalid = 0;
            if (aw_q.size() > 0 && wd_q.size() > 0) begin
                idx = aw_q.pop_front();
                d = wd_q.pop_front();
                s = ws_q.pop_front();
                e_bvalid = 1;
                e_bresp = idx < NRW ? 2'b00 : 2'b10;
                if (idx < NRW) begin
                    for (int b = 0; b < 4; b++) if (s[b]) m_rw[idx][8*b +: 8] = d[8*b +: 8];
                    e_wp[idx] = 1'b1;
                end
            end else begin
                if (AWVALID && e_awready) aw_q.push_back(dec(AWADDR));
                if (WVALID && e_wready) begin
                    wd_q.push_back(WDATA);
                    ws_q.push_back(WSTRB);
                end
            end
        end
        e_awready = ARESETN && aw_q.size() == 0 && !e_bvalid;
        e_wready  = ARESETN && wd_q.size() == 0 && !e_bvalid;
        e_arready = ARESETN && !e_rvalid;
    end

    always @(negedge ACLK) if (started) begin
        chk("AWREADY", AWREADY, e_awready);
        chk("WREADY", WREADY, e_wready);
        chk("ARREADY", ARREADY, e_arready);
        chk("BVALID", BVALID, e_bvalid);
        chk("BRESP", BRESP, e_bresp);
        chk("RVALID", RVALID, e_rvalid);
        chk("RRESP", RRESP, e_rresp);
        chk("RDATA", RDATA, e_rdata);
        chk("rw_wr_pulse", rw_wr_pulse, e_wp);
        chk("ro_rd_pulse", ro_rd_pulse, e_rp);
        for (int i = 0; i < NRW; i++) chk("rw_data", rw_data[i*DW +: DW], m_rw[i]);
    end

    int wp_cnt[NRW], rp_cnt[NRO];
    always @(negedge ACLK) if (started) begin
        for (int i = 0; i < NRW; i++) if (rw_wr_pulse[i]) wp_cnt[i]++;
        for (int j = 0; j < NRO; j++) if (ro_rd_pulse[j]) rp_cnt[j]++;
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // b_dly < 0 leaves BREADY low and returns once BVALID is seen
    task automatic do_write(input logic [31:0] addr, input logic [DW-1:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly, output logic [1:0] resp);
        bit ad = 0, wd = 0, ah, wh;
        int cyc = 0;
        resp = 2'bxx;
        while (!(ad && wd)) begin
            if (cyc == aw_dly && !ad) begin AWADDR = addr; AWVALID = 1'b1; end
            if (cyc == w_dly && !wd) begin WDATA = data; WSTRB = strb; WVALID = 1'b1; end
            @(negedge ACLK);
            ah = AWVALID && AWREADY;
            wh = WVALID && WREADY;
            tick();
            if (ah) begin AWVALID = 1'b0; ad = 1; end
            if (wh) begin WVALID = 1'b0; wd = 1; end
            if (++cyc > 60) begin
                timeout("aw/w handshake");
                AWVALID = 1'b0;
                WVALID = 1'b0;
                return;
            end
        end
        cyc = 0;
        BREADY = b_dly == 0;
        forever begin
            @(negedge ACLK);
            if (BVALID && (BREADY || b_dly < 0)) begin
                resp = BRESP;
                if (b_dly >= 0) begin
                    tick();
                    BREADY = 1'b0;
                end
                return;
            end
            tick();
            cyc++;
            if (b_dly >= 0 && cyc >= b_dly) BREADY = 1'b1;
            if (cyc > 80) begin
                timeout("b response");
                BREADY = 1'b0;
                return;
            end
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input int r_dly,
                           output logic [DW-1:0] data, output logic [1:0] resp);
        bit h;
        int cyc = 0;
        data = 'x;
        resp = 2'bxx;
        ARADDR = addr;
        ARVALID = 1'b1;
        do begin
            @(negedge ACLK);
            h = ARVALID && ARREADY;
            tick();
            if (++cyc > 60) begin
                timeout("ar handshake");
                ARVALID = 1'b0;
                return;
            end
        end while (!h);
        ARVALID = 1'b0;
        cyc = 0;
        forever begin
            RREADY = cyc >= r_dly;
            @(negedge ACLK);
            if (RVALID && RREADY) begin
                data = RDATA;
                resp = RRESP;
                tick();
                RREADY = 1'b0;
                return;
            end
            tick();
            if (++cyc > 80) begin
                timeout("r response");
                RREADY = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] br, rr;
        logic [DW-1:0] rd;
        int w0, r0, idx;
        logic [31:0] addr;
        ro_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        repeat (3) tick();
        chk("rst_rw3", rw_data[3*DW +: DW], 32'h7703);
        chk("rst_awready", AWREADY, 1'b0);
        ARESETN = 1'b1;
        tick();
        chk("ready_after_rst", {AWREADY, WREADY, ARREADY}, 3'b111);

        for (int i = 0; i < NRW; i++) begin
            do_read(32'(i * 4), 0, rd, rr);
            chk("rst_read", rd, 32'h7700 + i);
            chk("rst_read_resp", rr, 2'b00);
        end

        w0 = wp_cnt[1];
        do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, br);
        chk("w1_resp", br, 2'b00);
        chk("w1_data", rw_data[1*DW +: DW], 32'hDEADBEEF);
        chk("w1_pulses", wp_cnt[1] - w0, 1);
        do_write(32'h04, 32'h00001234, 4'h3, 0, 0, 0, br);
        chk("w1_strb", rw_data[1*DW +: DW], 32'hDEAD1234);

        w0 = wp_cnt[2];
        do_write(32'h08, 32'hCAFE0002, 4'hF, 3, 0, 0, br);
        chk("w_first_data", rw_data[2*DW +: DW], 32'hCAFE0002);
        chk("w_first_pulses", wp_cnt[2] - w0, 1);

        do_write(32'h20, 32'h11111111, 4'hF, 0, 1, 0, br);
        chk("ro_write_resp", br, 2'b10);
        do_write(32'h38, 32'h22222222, 4'hF, 1, 0, 0, br);
        chk("oor_write_resp", br, 2'b10);
        do_read(32'h38, 0, rd, rr);
        chk("oor_read_data", rd, 32'h0);
        chk("oor_read_resp", rr, 2'b10);
        do_read(32'h1000_0043, 0, rd, rr);
        chk("alias_read", rd, 32'h7700);

        ro_data[0 +: DW] = 32'h0000A5A5;
        r0 = rp_cnt[0];
        do_read(32'h20, 4, rd, rr);
        chk("ro_read", rd, 32'h0000A5A5);
        chk("ro_read_resp", rr, 2'b00);
        chk("ro_pulses", rp_cnt[0] - r0, 1);
        do_write(32'h14, 32'h87654321, 4'hF, 0, 0, 5, br);
        chk("bready_late_data", rw_data[5*DW +: DW], 32'h87654321);

        do_write(32'h0C, 32'h00000055, 4'hF, 0, 0, -1, br);
        chk("pre_rst_data", rw_data[3*DW +: DW], 32'h55);
        ARESETN = 1'b0;
        tick();
        tick();
        ARESETN = 1'b1;
        chk("mid_rst_bvalid", BVALID, 1'b0);
        chk("mid_rst_rw3", rw_data[3*DW +: DW], 32'h7703);
        tick();
        do_write(32'h0C, 32'h00000066, 4'hF, 0, 0, 0, br);
        chk("post_rst_write", rw_data[3*DW +: DW], 32'h66);

        for (int it = 0; it < 300; it++) begin
            logic [31:0] a2;
            logic [DW-1:0] d2;
            ro_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            idx = $urandom_range(0, MOD - 1);
            addr = ($urandom & 32'hFFFF_FFC0) | 32'(idx << 2) | 32'($urandom_range(0, 3));
            a2 = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, MOD - 1) << 2);
            d2 = $urandom;
            case ($urandom_range(0, 2))
                0: do_write(addr, d2, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                            $urandom_range(0, 2), br);
                1: do_read(addr, $urandom_range(0, 2), rd, rr);
                default: fork
                    do_write(addr, d2, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                             $urandom_range(0, 2), br);
                    do_read($urandom_range(0, 1) ? addr : a2, $urandom_range(0, 2), rd, rr);
                join
            endcase
        end
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
